operand_serializer: RTL and testbench
=====================================

Name: operand_serializer

Overview:
- Parallel-to-serial transmitter that feeds the bit-serial arithmetic section.
- Loads a parallel data word from the memory/transfer register and emits it LSB-first, one bit per bit-time strobe.
- Drives the framing flags the arithmetic section's carry, AND and result logic uses to detect first and last bit-time.
- Recirculates the word, so after a full pass the register again holds the original operand.

Parameters:
- WORD_W, 26, data bits per word (sign + 25 magnitude), transmitted LSB first.
- CNT_W, 5, bit-time counter width; must satisfy 2**CNT_W >= WORD_W.

Ports:
- v1  input  1  single bit-phase clock, rising edge; all state changes on it.
- rst_n  input  1  reset; asynchronous, active-low.
- bit_en  input  1  bit-time strobe; one shift per cycle it is high.
- load_valid  input  1  sequencer offers a word.
- load_ready  output  1  serializer accepts word this cycle.
- load_data  input  WORD_W  parallel operand.
- load_par  input  1  stored odd-parity bit of load_data (used only with feature).
- abort  input  1  synchronous cancel of the current pass.
- ser_bit  output  1  current serial operand bit.
- ser_valid  output  1  ser_bit is meaningful this bit-time.
- first_bit  output  1  high while bit 0 is presented.
- last_bit  output  1  high while bit WORD_W-1 (sign) is presented.
- bit_idx  output  CNT_W  index of the bit being presented.
- word_q  output  WORD_W  shift register contents (recirculated).
- busy  output  1  pass in progress.
- par_err  output  1  parity error sticky flag (feature only; tied 0 otherwise).

Behaviour:
- Reset values: word_q=0, bit_idx=0, busy=0, ser_valid=0, ser_bit=0, first_bit=0, last_bit=0, par_err=0, state=IDLE. Reset mid-pass discards the word immediately.
- States: IDLE, ARMED, SHIFT.
- IDLE:
  - load_ready=1.
  - load_valid&load_ready: capture load_data into word_q, bit_idx=0, go to ARMED.
- ARMED:
  - ser_valid=1, ser_bit=word_q[0], first_bit=1.
  - Bit 0 is presented one clock after acceptance and held until bit_en.
  - bit_en: rotate word_q right by 1 (bit 0 into MSB), bit_idx+1, go to SHIFT.
- SHIFT:
  - ser_bit=word_q[0], first_bit=0, last_bit=(bit_idx==WORD_W-1).
  - bit_en with last_bit: final rotate restores the original word; bit_idx=0.
  - If load_valid that same cycle, load_ready=1 and the new word is captured. Back-to-back rule: the next state is ARMED and the new word overrides the rotated value.
  - Otherwise the next state is IDLE.
- Without bit_en, all state holds; outputs are stable.
- busy=1 in ARMED and SHIFT.
- load_ready=0 in ARMED and in SHIFT except on the last_bit&bit_en cycle.
- abort has priority over bit_en and load:
  - Next state IDLE, bit_idx=0, word_q holds its partially rotated value.
  - load_ready is 0 in the abort cycle.
- Latency: load acceptance to ser_valid = 1 clock. A pass is exactly WORD_W bit_en strobes.
- bit_idx never exceeds WORD_W-1; no wrap beyond it.

Optional Feature:
- Macro: OPERAND_PARITY_CHK_EN.
- With it:
  - On load, compute the odd parity of {load_data, load_par}. If it is even, set par_err on the next clock.
  - par_err stays sticky until rst_n or the next accepted load with good parity.
  - The word is still transmitted.
- Without it: par_err is constant 0 and load_par is ignored.

Decomposition:
- Shared package lvdc_pkg:
  - WORD_W / CNT_W constants.
  - Serializer state enum (IDLE, ARMED, SHIFT).
  - Odd-parity function (reused by the memory-side writer).
- One natural sub-module: bit_time_counter, holding bit_idx, first/last decode and clear/increment on bit_en.

Test Plan:
- Reset, then load 26'h0000001 and strobe bit_en each clock -> ser_bit 1 at idx 0, 0 at idx 1..25. first_bit only at idx 0, last_bit only at idx 25, busy drops after the 26th strobe, word_q==26'h0000001.
- Load 26'h2AAAAAA with bit_en every third clock -> ser_bit alternates 0,1,...,1 per strobe and is held stable between strobes. Total 26 strobes; load_ready=0 throughout the pass.
- Back-to-back: hold load_valid with 26'h3FFFFFF during the last_bit strobe of 26'h0000000 -> load_ready=1 that cycle, next bit presented is 1 at idx 0, no idle gap.
- abort at idx 10 of 26'h1234567 -> next cycle busy=0, bit_idx=0, load_ready=1; a fresh load of 26'h0000005 then transmits 1,0,1,0... correctly.
- rst_n low at idx 7, released asynchronously mid-cycle -> all outputs at reset values immediately, state IDLE.
- With OPERAND_PARITY_CHK_EN: load 26'h0000003 with load_par=0 -> par_err=1 next clock. A subsequent load of 26'h0000001 with load_par=0 -> par_err clears.

Source files
------------

// File: rtl/lvdc_pkg.sv
// Shared constants, serializer state encoding and the odd-parity helper
// used by both the operand serializer and the memory-side writer.
package lvdc_pkg;

  localparam int WORD_W = 26;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SHIFT = 2'd2
  } ser_state_t;

  // Parity bit that makes {d, bit} contain an odd number of ones.
  function automatic logic odd_par_bit(input logic [WORD_W-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/operand_serializer_if.sv
// Load handshake between the sequencer (master) and the operand serializer (slave).
interface operand_serializer_if;
  import lvdc_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [WORD_W-1:0] load_data;
  logic              load_par;

  modport master (output load_valid, output load_data, output load_par, input load_ready);
  modport slave  (input load_valid, input load_data, input load_par, output load_ready);

endinterface

// File: rtl/operand_serializer_bit_time_counter.sv
// Bit-time index for the serializer: clear/increment on request, saturates
// at the sign bit, and decodes first/last bit-time.
module bit_time_counter
  import lvdc_pkg::*;
(
  input  logic             v1,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] bit_idx,
  output logic             at_first,
  output logic             at_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORD_W - 1);

  always_ff @(posedge v1 or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
    end else if (clr) begin
      bit_idx <= '0;
    end else if (inc && !at_last) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  assign at_first = (bit_idx == '0);
  assign at_last  = (bit_idx == LAST_IDX);

endmodule

// File: rtl/operand_serializer.sv
// Parallel-to-serial operand transmitter, LSB first, recirculating the word.
// Optional load parity check enabled by OPERAND_PARITY_CHK_EN.
//
// state | meaning
// IDLE  | waiting for a word, load_ready high
// ARMED | bit 0 presented, waiting for the first bit_en
// SHIFT | bits 1..WORD_W-1 presented, one per bit_en
module operand_serializer
  import lvdc_pkg::*;
(
  input  logic                 v1,
  input  logic                 rst_n,
  input  logic                 bit_en,
  input  logic                 abort,
  operand_serializer_if.slave  ld,
  output logic                 ser_bit,
  output logic                 ser_valid,
  output logic                 first_bit,
  output logic                 last_bit,
  output logic [CNT_W-1:0]     bit_idx,
  output logic [WORD_W-1:0]    word_q,
  output logic                 busy,
  output logic                 par_err
);

  ser_state_t        state, state_d;
  logic [WORD_W-1:0] word_d;
  logic              cnt_clr, cnt_inc, at_first, at_last, load_rdy;

  bit_time_counter u_cnt (
    .v1       (v1),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .bit_idx  (bit_idx),
    .at_first (at_first),
    .at_last  (at_last)
  );

  always_ff @(posedge v1 or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      word_q <= '0;
    end else begin
      state  <= state_d;
      word_q <= word_d;
    end
  end

  always_comb begin
    state_d   = state;
    word_d    = word_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    load_rdy  = 1'b0;
    busy      = 1'b0;
    ser_valid = 1'b0;
    ser_bit   = 1'b0;
    first_bit = 1'b0;
    last_bit  = 1'b0;
    case (state)
      IDLE: begin
        load_rdy = 1'b1;
        if (ld.load_valid) begin
          word_d  = ld.load_data;
          cnt_clr = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_bit   = word_q[0];
        first_bit = at_first;
        if (bit_en) begin
          word_d  = {word_q[0], word_q[WORD_W-1:1]};
          cnt_inc = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_bit   = word_q[0];
        last_bit  = at_last;
        if (bit_en) begin
          word_d = {word_q[0], word_q[WORD_W-1:1]};
          if (at_last) begin
            // Final rotate restores the operand unless a back-to-back load replaces it.
            cnt_clr  = 1'b1;
            load_rdy = 1'b1;
            if (ld.load_valid) begin
              word_d  = ld.load_data;
              state_d = ARMED;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      word_d   = word_q;
      cnt_clr  = 1'b1;
      cnt_inc  = 1'b0;
      load_rdy = 1'b0;
    end
  end

  assign ld.load_ready = load_rdy;

`ifdef OPERAND_PARITY_CHK_EN
  logic par_err_q;

  always_ff @(posedge v1 or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (ld.load_valid && load_rdy) begin
      par_err_q <= (ld.load_par != odd_par_bit(ld.load_data));
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_operand_serializer.sv
// Directed self-checking bench for operand_serializer.
module tb_operand_serializer;
  import lvdc_pkg::*;

  logic              v1, rst_n, bit_en, abort;
  logic              ser_bit, ser_valid, first_bit, last_bit, busy, par_err;
  logic [CNT_W-1:0]  bit_idx;
  logic [WORD_W-1:0] word_q;
  int                n_chk = 0;
  int                n_pass = 0;

  operand_serializer_if ld_if ();

  operand_serializer dut (
    .v1        (v1),
    .rst_n     (rst_n),
    .bit_en    (bit_en),
    .abort     (abort),
    .ld        (ld_if),
    .ser_bit   (ser_bit),
    .ser_valid (ser_valid),
    .first_bit (first_bit),
    .last_bit  (last_bit),
    .bit_idx   (bit_idx),
    .word_q    (word_q),
    .busy      (busy),
    .par_err   (par_err)
  );

  initial begin
    v1 = 1'b0;
    forever #5 v1 = ~v1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge v1);
    #1;
  endtask

  task automatic do_load(input logic [WORD_W-1:0] d, input logic p);
    tick();
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = d;
    ld_if.load_par   = p;
    tick();
    ld_if.load_valid = 1'b0;
    #1;
  endtask

  // Loads d and strobes a full pass, bit_en every gap clocks; optional back-to-back load.
  task automatic run_pass(input logic [WORD_W-1:0] d, input int gap, input logic b2b,
                          input logic [WORD_W-1:0] nd,
                          output logic [WORD_W-1:0] bits, output logic [WORD_W-1:0] firsts,
                          output logic [WORD_W-1:0] lasts, output int held_err,
                          output int ready_err, output int idx_err, output logic rdy_last);
    held_err = 0; ready_err = 0; idx_err = 0; rdy_last = 1'b0;
    bits = '0; firsts = '0; lasts = '0;
    tick();
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = d;
    ld_if.load_par   = ~(^d);
    tick();
    ld_if.load_valid = 1'b0;
    for (int k = 0; k < WORD_W; k++) begin
      for (int j = 0; j < gap; j++) begin
        bit_en = (j == gap - 1);
        if (b2b && k == WORD_W - 1 && j == gap - 1) begin
          ld_if.load_valid = 1'b1;
          ld_if.load_data  = nd;
        end
        #1;
        if (j == 0) begin
          bits[k]   = ser_bit;
          firsts[k] = first_bit;
          lasts[k]  = last_bit;
          if (int'(bit_idx) != k) idx_err++;
        end else if (ser_bit !== bits[k] || int'(bit_idx) != k) begin
          held_err++;
        end
        if (!ser_valid || !busy) held_err++;
        if (k == WORD_W - 1 && j == gap - 1) rdy_last = ld_if.load_ready;
        else if (ld_if.load_ready) ready_err++;
        tick();
      end
    end
    bit_en = 1'b0;
    ld_if.load_valid = 1'b0;
  endtask

  logic [WORD_W-1:0] bits, firsts, lasts, exp_w;
  int                held_err, ready_err, idx_err;
  logic              rdy_last;

  initial begin
    rst_n = 1'b0; bit_en = 1'b0; abort = 1'b0;
    ld_if.load_valid = 1'b0; ld_if.load_data = '0; ld_if.load_par = 1'b0;
    #12;
    check("rst_word_q", word_q, 0);
    check("rst_bit_idx", bit_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_ser_valid", ser_valid, 0);
    check("rst_flags", {ser_bit, first_bit, last_bit, par_err}, 0);
    rst_n = 1'b1;

    // Single one in bit 0, strobe every clock
    run_pass(26'h0000001, 1, 1'b0, '0, bits, firsts, lasts, held_err, ready_err, idx_err, rdy_last);
    check("p1_bits", bits, 26'h0000001);
    check("p1_first", firsts, 26'h0000001);
    check("p1_last", lasts, 26'h2000000);
    check("p1_idx_err", idx_err, 0);
    check("p1_valid_err", held_err, 0);
    check("p1_ready_in_pass", ready_err, 0);
    check("p1_ready_last", rdy_last, 1);
    #1;
    check("p1_busy_after", busy, 0);
    check("p1_word_restored", word_q, 26'h0000001);
    check("p1_ready_idle", ld_if.load_ready, 1);

    // Alternating pattern, strobe every third clock
    run_pass(26'h2AAAAAA, 3, 1'b0, '0, bits, firsts, lasts, held_err, ready_err, idx_err, rdy_last);
    check("p2_bits", bits, 26'h2AAAAAA);
    check("p2_held_err", held_err, 0);
    check("p2_ready_in_pass", ready_err, 0);
    check("p2_idx_err", idx_err, 0);
    #1;
    check("p2_busy_after", busy, 0);
    check("p2_word_restored", word_q, 26'h2AAAAAA);

    // Back-to-back: all-zero pass followed immediately by all-ones
    run_pass(26'h0000000, 1, 1'b1, 26'h3FFFFFF, bits, firsts, lasts, held_err, ready_err, idx_err, rdy_last);
    check("p3_bits", bits, 26'h0000000);
    check("p3_ready_b2b", rdy_last, 1);
    #1;
    check("p3_busy_no_gap", busy, 1);
    check("p3_next_bit", {ser_valid, ser_bit, first_bit}, 3'b111);
    check("p3_next_idx", bit_idx, 0);
    check("p3_next_word", word_q, 26'h3FFFFFF);
    // abort cleans up; load_ready must stay low in the abort cycle
    abort = 1'b1;
    #1;
    check("p3_abort_ready", ld_if.load_ready, 0);
    tick();
    abort = 1'b0;

    // Abort at idx 10 with bit_en also high
    do_load(26'h1234567, 1'b0);
    bit_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("p4_idx_before_abort", bit_idx, 10);
    abort = 1'b1;
    #1;
    check("p4_abort_ready", ld_if.load_ready, 0);
    tick();
    abort = 1'b0; bit_en = 1'b0;
    #1;
    exp_w = 26'h1234567;
    exp_w = {exp_w[9:0], exp_w[25:10]};
    check("p4_busy", busy, 0);
    check("p4_idx", bit_idx, 0);
    check("p4_ready", ld_if.load_ready, 1);
    check("p4_word_partial", word_q, exp_w);
    run_pass(26'h0000005, 1, 1'b0, '0, bits, firsts, lasts, held_err, ready_err, idx_err, rdy_last);
    check("p4_fresh_bits", bits, 26'h0000005);
    check("p4_fresh_idx_err", idx_err, 0);

    // Asynchronous reset mid-pass
    do_load(26'h1234567, 1'b0);
    bit_en = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bit_en = 1'b0;
    #1;
    check("p5_idx_before_rst", bit_idx, 7);
    #1;
    rst_n = 1'b0;
    #1;
    check("p5_rst_word", word_q, 0);
    check("p5_rst_idx", bit_idx, 0);
    check("p5_rst_outs", {busy, ser_valid, ser_bit, first_bit, last_bit, par_err}, 0);
    check("p5_rst_idle_ready", ld_if.load_ready, 1);
    #1;
    rst_n = 1'b1;
    tick();
    check("p5_after_busy", busy, 0);
    check("p5_after_idx", bit_idx, 0);

    // Parity: bad then good
    do_load(26'h0000003, 1'b0);
`ifdef OPERAND_PARITY_CHK_EN
    check("p6_par_err_set", par_err, 1);
`else
    check("p6_par_err_off", par_err, 0);
`endif
    check("p6_word_sent", {ser_valid, ser_bit}, 2'b11);
    abort = 1'b1;
    tick();
    abort = 1'b0;
`ifdef OPERAND_PARITY_CHK_EN
    check("p6_par_err_sticky", par_err, 1);
`endif
    do_load(26'h0000001, 1'b0);
    check("p6_par_err_clear", par_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
